// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - fetch/decode/execute sequencer owning all bus drive enables
// Moore FSM: every strobe is a pure decode of the registered state.
module control_sequencer #(
  parameter int          MEM_LAT     = 1,
  parameter int          ALU_TIMEOUT = 15,
  parameter logic [3:0]  HALT_OP     = 4'hF,
  parameter logic [15:0] CNT_INIT    = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [3:0]  opCode,
  input  logic        ALUstr,
  input  logic        MOVstr,
  input  logic        LDSRstr,
  input  logic        alu_done,
  output logic        mem_rd,
  output logic        pc_inc,
  output logic        IF,
  output logic        IR,
  output logic        IRiEn,
  output logic        IRjEn,
  output logic        BRjEn,
  output logic        reg_rd_en,
  output logic        reg_wr_en,
  output logic        alu_lda,
  output logic        alu_start,
  output logic        alu_oe,
  output logic        busy,
  output logic        halted,
  output logic        fault,
  output logic [15:0] instr_cnt
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_LOAD_IR, S_DECODE, S_IMM, S_MOV_RD, S_MOV_WR,
    S_ALU_A, S_ALU_B, S_ALU_WAIT, S_ALU_WB, S_NOP, S_HALT
  } state_t;

  localparam int CW = 16;
  localparam logic [CW-1:0] FETCH_LAST = CW'(MEM_LAT - 1);
  localparam logic [CW-1:0] WAIT_LAST  = CW'(ALU_TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fault_q, fault_d;
  logic [15:0]   icnt_q, icnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      fault_q <= 1'b0;
      icnt_q  <= CNT_INIT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      icnt_q  <= icnt_d;
    end
  end

  // cnt_q is shared by FETCH and ALU_WAIT; it returns to zero whenever it is not counting.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    fault_d = fault_q;
    icnt_d  = icnt_q;
    case (state_q)
      S_IDLE:    if (run) state_d = S_FETCH;
      S_FETCH: begin
        if (cnt_q == FETCH_LAST) state_d = S_LOAD_IR;
        else                     cnt_d   = cnt_q + CW'(1);
      end
      S_LOAD_IR: state_d = S_DECODE;
      S_DECODE: begin
        if (opCode == HALT_OP) state_d = S_HALT;
        else if (LDSRstr)      state_d = S_IMM;
        else if (MOVstr)       state_d = S_MOV_RD;
        else if (ALUstr)       state_d = S_ALU_A;
        else                   state_d = S_NOP;
      end
      S_MOV_RD:  state_d = S_MOV_WR;
      S_ALU_A:   state_d = S_ALU_B;
      S_ALU_B:   state_d = S_ALU_WAIT;
      S_ALU_WAIT: begin
        if (alu_done) begin
          state_d = S_ALU_WB;
        end else if (cnt_q == WAIT_LAST) begin
          state_d = S_HALT;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_IMM, S_MOV_WR, S_ALU_WB, S_NOP: begin
        icnt_d  = icnt_q + 16'd1;
        state_d = run ? S_FETCH : S_IDLE;
      end
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_rd    = 1'b0;
    pc_inc    = 1'b0;
    IF        = 1'b0;
    IR        = 1'b0;
    IRiEn     = 1'b0;
    IRjEn     = 1'b0;
    BRjEn     = 1'b0;
    reg_rd_en = 1'b0;
    reg_wr_en = 1'b0;
    alu_lda   = 1'b0;
    alu_start = 1'b0;
    alu_oe    = 1'b0;
    busy      = (state_q != S_IDLE) && (state_q != S_HALT);
    halted    = (state_q == S_HALT);
    case (state_q)
      S_FETCH:   begin mem_rd = 1'b1; IF = 1'b1; end
      S_LOAD_IR: begin IR = 1'b1; pc_inc = 1'b1; end
      S_IMM:     begin IRiEn = 1'b1; BRjEn = 1'b1; reg_wr_en = 1'b1; end
      S_MOV_RD:  begin IRjEn = 1'b1; reg_rd_en = 1'b1; end
      // Register-file latch keeps the read value on the bus, so no driver here.
      S_MOV_WR:  begin IRiEn = 1'b1; reg_wr_en = 1'b1; end
      S_ALU_A:   begin IRiEn = 1'b1; reg_rd_en = 1'b1; alu_lda = 1'b1; end
      S_ALU_B:   begin IRjEn = 1'b1; reg_rd_en = 1'b1; alu_start = 1'b1; end
      S_ALU_WB:  begin IRiEn = 1'b1; alu_oe = 1'b1; reg_wr_en = 1'b1; end
      default:   ;
    endcase
  end

  assign fault     = fault_q;
  assign instr_cnt = icnt_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - self-checking bench for control_sequencer
// Expected output vectors come from a per-instruction phase table; one process compares every cycle.
module tb_control_sequencer;

  localparam int ALU_TO = 15;
  localparam int B_MEM = 14, B_PC = 13, B_IF = 12, B_IR = 11, B_RI = 10, B_RJ = 9, B_BRJ = 8;
  localparam int B_RRD = 7, B_RWR = 6, B_LDA = 5, B_STA = 4, B_OE = 3, B_BUSY = 2, B_HALT = 1;
  localparam logic [14:0] ONE    = 15'd1;
  localparam logic [14:0] P_IDLE = 15'd0;
  localparam logic [14:0] P_FETCH = (ONE << B_MEM) | (ONE << B_IF) | (ONE << B_BUSY);
  localparam logic [14:0] P_LOAD  = (ONE << B_IR) | (ONE << B_PC) | (ONE << B_BUSY);
  localparam logic [14:0] P_DEC   = (ONE << B_BUSY);
  localparam logic [14:0] P_IMM   = (ONE << B_RI) | (ONE << B_BRJ) | (ONE << B_RWR) | (ONE << B_BUSY);
  localparam logic [14:0] P_MOVR  = (ONE << B_RJ) | (ONE << B_RRD) | (ONE << B_BUSY);
  localparam logic [14:0] P_MOVW  = (ONE << B_RI) | (ONE << B_RWR) | (ONE << B_BUSY);
  localparam logic [14:0] P_ALUA  = (ONE << B_RI) | (ONE << B_RRD) | (ONE << B_LDA) | (ONE << B_BUSY);
  localparam logic [14:0] P_ALUB  = (ONE << B_RJ) | (ONE << B_RRD) | (ONE << B_STA) | (ONE << B_BUSY);
  localparam logic [14:0] P_WAIT  = (ONE << B_BUSY);
  localparam logic [14:0] P_WB    = (ONE << B_RI) | (ONE << B_OE) | (ONE << B_RWR) | (ONE << B_BUSY);
  localparam logic [14:0] P_NOP   = (ONE << B_BUSY);
  localparam logic [14:0] P_HALT  = (ONE << B_HALT);
  localparam int K_IMM = 0, K_MOV = 1, K_ALU = 2, K_NOP = 3, K_HALT = 4;

  typedef struct packed {
    int unsigned cyc;
    logic [14:0] vec;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1, run = 1'b0, ALUstr = 1'b0, MOVstr = 1'b0, LDSRstr = 1'b0, alu_done = 1'b0;
  logic [3:0] opCode = 4'h0;
  logic mem_rd, pc_inc, IF, IR, IRiEn, IRjEn, BRjEn, reg_rd_en, reg_wr_en;
  logic alu_lda, alu_start, alu_oe, busy, halted, fault;
  logic [15:0] instr_cnt;

  logic reset3 = 1'b1, run3 = 1'b0;
  logic mem_rd3, pc_inc3, IF3, IR3, IRiEn3, IRjEn3, BRjEn3, reg_rd_en3, reg_wr_en3;
  logic alu_lda3, alu_start3, alu_oe3, busy3, halted3, fault3;
  logic [15:0] instr_cnt3;

  int tot = 0, bad = 0;
  int unsigned cyc_n = 0;
  exp_t expq[$];
  exp_t ce;
  logic [15:0] m_cnt = 16'd0;
  bit m_fault = 1'b0, pend = 1'b0;
  logic ir_prev = 1'b0;
  logic [14:0] act;

  control_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .opCode(opCode), .ALUstr(ALUstr), .MOVstr(MOVstr),
    .LDSRstr(LDSRstr), .alu_done(alu_done), .mem_rd(mem_rd), .pc_inc(pc_inc), .IF(IF), .IR(IR),
    .IRiEn(IRiEn), .IRjEn(IRjEn), .BRjEn(BRjEn), .reg_rd_en(reg_rd_en), .reg_wr_en(reg_wr_en),
    .alu_lda(alu_lda), .alu_start(alu_start), .alu_oe(alu_oe), .busy(busy), .halted(halted),
    .fault(fault), .instr_cnt(instr_cnt)
  );

  control_sequencer #(.MEM_LAT(3), .CNT_INIT(16'hFFFF)) dut3 (
    .clk(clk), .reset(reset3), .run(run3), .opCode(4'h2), .ALUstr(1'b0), .MOVstr(1'b0),
    .LDSRstr(1'b1), .alu_done(1'b0), .mem_rd(mem_rd3), .pc_inc(pc_inc3), .IF(IF3), .IR(IR3),
    .IRiEn(IRiEn3), .IRjEn(IRjEn3), .BRjEn(BRjEn3), .reg_rd_en(reg_rd_en3), .reg_wr_en(reg_wr_en3),
    .alu_lda(alu_lda3), .alu_start(alu_start3), .alu_oe(alu_oe3), .busy(busy3), .halted(halted3),
    .fault(fault3), .instr_cnt(instr_cnt3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  assign act = {mem_rd, pc_inc, IF, IR, IRiEn, IRjEn, BRjEn, reg_rd_en, reg_wr_en,
                alu_lda, alu_start, alu_oe, busy, halted, fault};

  always @(negedge clk) begin
    if (expq.size() > 0 && expq[0].cyc == cyc_n) begin
      ce = expq.pop_front();
      tot++;
      if (act !== ce.vec || instr_cnt !== ce.cnt) begin
        bad++;
        $display("FAIL seq cyc=%0d got vec=%b cnt=%h want vec=%b cnt=%h",
                 cyc_n, act, instr_cnt, ce.vec, ce.cnt);
      end
    end
    tot++;
    if ((IRiEn && IRjEn) || !$onehot0({reg_rd_en, BRjEn, alu_oe}) || (IR && ir_prev)) begin
      bad++;
      $display("FAIL invariant cyc=%0d got ri=%b rj=%b bus=%b ir=%b/%b want exclusive",
               cyc_n, IRiEn, IRjEn, {reg_rd_en, BRjEn, alu_oe}, ir_prev, IR);
    end
    ir_prev = IR;
  end

  task automatic lit(input string nm, input logic [15:0] got, input logic [15:0] want);
    tot++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  // Queue the outputs expected after the coming edge, then advance to just past it.
  task automatic step(input logic [14:0] v);
    exp_t e;
    if (pend) begin
      m_cnt = m_cnt + 16'd1;
      pend  = 1'b0;
    end
    e.cyc = cyc_n + 1;
    e.vec = v | {14'd0, m_fault};
    e.cnt = m_cnt;
    expq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic junk(input bit r);
    run = r; opCode = 4'hF; ALUstr = 1'b1; MOVstr = 1'b1; LDSRstr = 1'b1; alu_done = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1; m_cnt = 16'd0; m_fault = 1'b0; pend = 1'b0;
    step(P_IDLE);
    reset = 1'b0;
  endtask

  task automatic idle_step();
    junk(1'b0);
    step(P_IDLE);
  endtask

  task automatic halt_hold(input int n);
    for (int i = 0; i < n; i++) begin
      junk(i[0]);
      step(P_HALT);
    end
  endtask

  // waitn: wait cycle on which alu_done arrives; 0 = never (timeout), -1 = reset on 2nd wait.
  task automatic instr(input int kind, input int waitn, input bit rb);
    junk(1'b1); step(P_FETCH);
    junk(rb);   step(P_LOAD);
    junk(rb);   step(P_DEC);
    alu_done = 1'b1; run = rb;
    case (kind)
      K_HALT: begin
        opCode = 4'hF; ALUstr = 1'b1; MOVstr = 1'b0; LDSRstr = 1'b0;
        step(P_HALT);
      end
      K_IMM: begin
        opCode = 4'h3; ALUstr = 1'b1; MOVstr = 1'b1; LDSRstr = 1'b1;
        step(P_IMM); pend = 1'b1;
      end
      K_MOV: begin
        opCode = 4'h5; ALUstr = 1'b1; MOVstr = 1'b1; LDSRstr = 1'b0;
        step(P_MOVR); junk(rb); step(P_MOVW); pend = 1'b1;
      end
      K_NOP: begin
        opCode = 4'hE; ALUstr = 1'b0; MOVstr = 1'b0; LDSRstr = 1'b0;
        step(P_NOP); pend = 1'b1;
      end
      default: begin
        opCode = 4'h1; ALUstr = 1'b1; MOVstr = 1'b0; LDSRstr = 1'b0;
        step(P_ALUA); junk(rb); step(P_ALUB); junk(rb); step(P_WAIT);
        for (int k = 1; k <= ALU_TO; k++) begin
          junk(rb);
          alu_done = (k == waitn);
          if (waitn < 0 && k == 2) begin do_reset(); break; end
          if (k == waitn) begin step(P_WB); pend = 1'b1; break; end
          if (k == ALU_TO) begin m_fault = 1'b1; step(P_HALT); break; end
          step(P_WAIT);
        end
      end
    endcase
  endtask

  task automatic mem_lat3_check();
    int n_mem, n_if, n_ir;
    n_mem = 0; n_if = 0; n_ir = 0;
    @(posedge clk); #1 reset3 = 1'b1;
    @(posedge clk); #1 reset3 = 1'b0;
    lit("lat3_reset_cnt", instr_cnt3, 16'hFFFF);
    lit("lat3_reset_busy", {15'd0, busy3}, 16'd0);
    run3 = 1'b1;
    @(posedge clk); #1 run3 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_mem += int'(mem_rd3);
      n_if  += int'(IF3);
      n_ir  += int'(IR3);
    end
    lit("lat3_mem_rd_cycles", 16'(n_mem), 16'd3);
    lit("lat3_if_cycles", 16'(n_if), 16'd3);
    lit("lat3_ir_cycles", 16'(n_ir), 16'd1);
    lit("lat3_cnt_wrap", instr_cnt3, 16'h0000);
    lit("lat3_idle_busy", {15'd0, busy3}, 16'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    @(posedge clk); #1;
    do_reset();
    idle_step();
    instr(K_IMM, 0, 1'b1);
    idle_step();
    lit("imm_cnt", instr_cnt, 16'd1);
    instr(K_ALU, 3, 1'b1);
    instr(K_NOP, 0, 1'b1);
    instr(K_MOV, 0, 1'b1);
    idle_step();
    lit("cnt_after_alu_nop_mov", instr_cnt, 16'd4);
    instr(K_MOV, 0, 1'b0);
    idle_step();
    lit("mov_run_drop_cnt", instr_cnt, 16'd5);
    lit("mov_run_drop_idle", {15'd0, busy}, 16'd0);
    instr(K_IMM, 0, 1'b1);
    instr(K_ALU, 0, 1'b1);
    lit("timeout_fault", {15'd0, fault}, 16'd1);
    lit("timeout_halted", {15'd0, halted}, 16'd1);
    lit("timeout_cnt", instr_cnt, 16'd6);
    halt_hold(4);
    do_reset();
    lit("reset_clears_fault", {15'd0, fault}, 16'd0);
    lit("reset_clears_cnt", instr_cnt, 16'd0);
    instr(K_HALT, 0, 1'b1);
    lit("halt_op_halted", {15'd0, halted}, 16'd1);
    halt_hold(5);
    lit("halt_op_cnt", instr_cnt, 16'd0);
    do_reset();
    instr(K_IMM, 0, 1'b1);
    instr(K_ALU, -1, 1'b1);
    lit("reset_mid_wait_busy", {15'd0, busy}, 16'd0);
    for (int n = 0; n < 24; n++) begin
      instr(int'($urandom_range(0, 3)), int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle_step();
    end
    idle_step();
    @(negedge clk); #1;
    lit("queue_drained", 16'(expq.size()), 16'd0);
    mem_lat3_check();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
